// File: rtl/tlul_pkg.sv
// TL-UL type definitions shared by the SRAM bridge and the hosts that drive it.
// Only the subset of TileLink-UL carried on the single-beat 32-bit fabric is
// modelled: A channel request plus d_ready (host->device), D channel response
// plus a_ready (device->host).
package tlul_pkg;

    // A channel opcodes
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    // D channel opcodes
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/student_tlul_sram_bridge.sv
// TL-UL device bridge onto a single-port synchronous SRAM macro.
// Decodes and checks Get / PutFullData / PutPartialData beats, strobes the
// SRAM in the accept cycle, and returns responses in order through a
// one-entry stage register followed by a RspDepth-entry response queue.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   tl_i           A channel + d_ready from the host
//   tl_o           a_ready + D channel to the host
//   mem_req_o      SRAM strobe (non-error accepted beat)
//   mem_we_o       1 = write
//   mem_addr_o     SRAM word address
//   mem_wdata_o    write data
//   mem_wmask_o    bit write-enable (byte mask expanded x8)
//   mem_rdata_i    read data, valid the cycle after a read strobe
//   busy_o         a response is in the stage register or queue
//   err_cnt_o      saturating count of accepted error beats
module student_tlul_sram_bridge
    import tlul_pkg::*;
#(
    parameter int          AddrWidth = 10,
    parameter logic [31:0] BaseAddr  = 32'h0001_0000,
    parameter int          RspDepth  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  tl_h2d_t              tl_i,
    output tl_d2h_t              tl_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [31:0]          mem_wmask_o,
    input  logic [31:0]          mem_rdata_i,
    output logic                 busy_o,
    output logic [15:0]          err_cnt_o
);

    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW = $clog2(RspDepth + 1);

    typedef struct packed {
        logic       err;
        logic       is_read;
        logic [7:0] source;
        logic [1:0] size;
    } stage_t;

    typedef struct packed {
        logic        err;
        logic        is_read;
        logic [7:0]  source;
        logic [1:0]  size;
        logic [31:0] data;
    } rsp_t;

    logic [CntW-1:0] occ;
    logic            stage_v;
    stage_t          stage_q;
    rsp_t            q_mem [RspDepth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;

    logic [CntW:0]   fill;
    logic            a_ready, accept, a_err;
    logic            is_get, is_pf, is_pp;
    logic            d_valid, push, pop;
    rsp_t            push_entry, head;

    logic            unused_param;
    assign unused_param = ^tl_i.a_param;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Accept only while the stage entry plus queued entries leave room, so the
    // stage entry always finds a free slot when it is pushed one cycle later.
    // Deliberately independent of d_ready.
    assign fill    = {1'b0, occ} + (CntW+1)'(stage_v);
    assign a_ready = !rst_i && (fill < (CntW+1)'(RspDepth));
    assign accept  = tl_i.a_valid & a_ready;

    assign is_get = (tl_i.a_opcode == Get);
    assign is_pf  = (tl_i.a_opcode == PutFullData);
    assign is_pp  = (tl_i.a_opcode == PutPartialData);

    assign a_err = (tl_i.a_address[31:AddrWidth+2] != BaseAddr[31:AddrWidth+2])
                 | (tl_i.a_address[1:0] != 2'b00)
                 | (tl_i.a_size != 2'd2)
                 | !(is_get | is_pf | is_pp)
                 | (is_pf & (tl_i.a_mask != 4'hF));

    // SRAM is driven straight from the A channel in the accept cycle
    assign mem_req_o   = accept & !a_err;
    assign mem_we_o    = !is_get;
    assign mem_addr_o  = tl_i.a_address[AddrWidth+1:2];
    assign mem_wdata_o = tl_i.a_data;

    always_comb begin
        mem_wmask_o = '0;
        for (int i = 0; i < 4; i++) begin
            mem_wmask_o[8*i +: 8] = {8{tl_i.a_mask[i]}};
        end
    end

    // The stage cycle coincides with the SRAM read-data cycle
    assign push = stage_v;
    always_comb begin
        push_entry         = '0;
        push_entry.err     = stage_q.err;
        push_entry.is_read = stage_q.is_read;
        push_entry.source  = stage_q.source;
        push_entry.size    = stage_q.size;
        push_entry.data    = (stage_q.is_read && !stage_q.err) ? mem_rdata_i : 32'h0;
    end

    assign head    = q_mem[rd_ptr];
    assign d_valid = (occ != '0);
    assign pop     = d_valid & tl_i.d_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_v   <= 1'b0;
            occ       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err_cnt_o <= '0;
        end else begin
            stage_v <= accept;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
            if (accept && a_err && (err_cnt_o != 16'hFFFF)) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end

    // Payload storage needs no reset: validity lives in stage_v / occ
    always_ff @(posedge clk_i) begin
        if (accept) begin
            stage_q.err     <= a_err;
            stage_q.is_read <= is_get;
            stage_q.source  <= tl_i.a_source;
            stage_q.size    <= tl_i.a_size;
        end
        if (push) q_mem[wr_ptr] <= push_entry;
    end

    // During reset every tl_o field is forced to zero
    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        if (!rst_i && d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = head.is_read ? AccessAckData : AccessAck;
            tl_o.d_error  = head.err;
            tl_o.d_source = head.source;
            tl_o.d_size   = head.size;
            tl_o.d_data   = head.data;
        end
    end

    assign busy_o = !rst_i & (stage_v | d_valid);

endmodule

// File: tb/tb_student_tlul_sram_bridge.sv
module tb_student_tlul_sram_bridge;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        mem_req_o, mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o, mem_wmask_o, mem_rdata_i;
    logic        busy_o;
    logic [15:0] err_cnt_o;

    student_tlul_sram_bridge #(.AddrWidth(10), .BaseAddr(32'h0001_0000), .RspDepth(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .tl_i(tl_i), .tl_o(tl_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    // SRAM model: write lands at the edge, read data registered at the edge
    logic [31:0] sram [1024];
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) sram[mem_addr_o] <= (sram[mem_addr_o] & ~mem_wmask_o) | (mem_wdata_o & mem_wmask_o);
            else          mem_rdata_i <= sram[mem_addr_o];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic        err;
        logic [7:0]  src;
        logic [31:0] data;
        bit          chk_lat;
        int          exp_cyc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    int n_acc = 0, n_memreq = 0, n_resp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every popped response against the scoreboard head
    exp_t e;
    always @(negedge clk) begin
        if (mem_req_o) n_memreq++;
        if (!rst_i && tl_o.d_valid && tl_i.d_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {31'h0, tl_o.d_valid}, 64'h0);
            end else begin
                e = sb.pop_front();
                chk("d_rsp", {tl_o.d_opcode, tl_o.d_param, tl_o.d_error, tl_o.d_sink,
                              tl_o.d_source, tl_o.d_size, tl_o.d_data},
                             {e.op, 3'h0, e.err, 1'b0, e.src, 2'd2, e.data});
                if (e.chk_lat) chk("d_latency", 64'(cyc), 64'(e.exp_cyc));
                n_resp++;
            end
        end
    end

    // Offer one beat; leaves a_valid asserted on acceptance so beats can stream
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [7:0] src, input logic exp_err,
                        input logic [31:0] exp_data, input bit lat, output int acc);
        int w = 0;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_param   = 3'h0;
        tl_i.a_size    = 2'd2;
        tl_i.a_source  = src;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        acc = -1;
        while (acc < 0 && w < 200) begin
            @(negedge clk);
            if (tl_o.a_ready) begin
                acc = cyc;
                n_acc++;
                sb.push_back('{(op == Get) ? AccessAckData : AccessAck, exp_err, src, exp_data, lat, cyc + 2});
            end
            @(posedge clk); #1;
            w++;
        end
        if (acc < 0) begin
            chk("accept_timeout", 64'h0, 64'h1);
            tl_i.a_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        tl_i.a_valid = 1'b0;
        while ((sb.size() != 0 || busy_o) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("drain_timeout", 64'(sb.size()), 64'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, first, last, rel, r0;
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        rst_i = 1'b1;
        // A legal beat held during reset must not be accepted or strobe the SRAM
        tl_i.a_valid = 1'b1; tl_i.a_opcode = Get; tl_i.a_size = 2'd2;
        tl_i.a_address = 32'h0001_0010; tl_i.a_mask = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready",  {63'h0, tl_o.a_ready}, 64'h0);
        chk("rst_tl_o",     64'(tl_o), 64'h0);
        chk("rst_mem_req",  {63'h0, mem_req_o}, 64'h0);
        chk("rst_busy",     {63'h0, busy_o}, 64'h0);
        chk("rst_err_cnt",  64'(err_cnt_o), 64'h0);
        @(posedge clk); #1;
        tl_i.a_valid = 1'b0;
        rst_i = 1'b0;
        rel = cyc;

        // Put then Get, back-to-back, latency checked
        send(PutFullData, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 8'd3, 1'b0, 32'h0, 1'b1, acc);
        chk("first_accept_cycle", 64'(acc), 64'(rel));
        send(Get, 32'h0001_0010, 32'h0, 4'hF, 8'd4, 1'b0, 32'hDEAD_BEEF, 1'b1, acc);
        drain();

        // Partial write
        send(PutFullData,    32'h0001_0020, 32'h1122_3344, 4'hF,    8'd1, 1'b0, 32'h0, 1'b1, acc);
        send(PutPartialData, 32'h0001_0020, 32'hAABB_CCDD, 4'b0101, 8'd2, 1'b0, 32'h0, 1'b1, acc);
        send(Get,            32'h0001_0020, 32'h0,         4'hF,    8'd5, 1'b0, 32'h11BB_33DD, 1'b1, acc);
        drain();

        // Error beats
        n_memreq = 0;
        send(Get,         32'h0000_0000, 32'h0,         4'hF, 8'd6, 1'b1, 32'h0, 1'b0, acc);
        send(Get,         32'h0001_0002, 32'h0,         4'hF, 8'd7, 1'b1, 32'h0, 1'b0, acc);
        send(PutFullData, 32'h0001_0030, 32'h1234_5678, 4'h3, 8'd8, 1'b1, 32'h0, 1'b0, acc);
        drain();
        chk("err_mem_req", 64'(n_memreq), 64'h0);
        chk("err_cnt", 64'(err_cnt_o), 64'd3);

        // Back-pressure: preload 6 words, then 6 Gets with d_ready low
        for (int i = 0; i < 6; i++)
            send(PutFullData, 32'h0001_0100 + 32'(4*i), {24'hC0FFEE, 8'(i)}, 4'hF, 8'(i), 1'b0, 32'h0, 1'b0, acc);
        drain();
        tl_i.d_ready = 1'b0;
        n_acc = 0;
        r0 = n_resp;
        fork
            begin
                int a;
                for (int i = 0; i < 6; i++)
                    send(Get, 32'h0001_0100 + 32'(4*i), 32'h0, 4'hF, 8'(10+i), 1'b0, {24'hC0FFEE, 8'(i)}, 1'b0, a);
                tl_i.a_valid = 1'b0;
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_accepted", 64'(n_acc), 64'd4);
                chk("bp_a_ready",  {63'h0, tl_o.a_ready}, 64'h0);
                @(posedge clk); #1;
                tl_i.d_ready = 1'b1;
            end
        join
        drain();
        chk("bp_responses", 64'(n_resp - r0), 64'd6);

        // Streaming: 64 back-to-back writes
        r0 = n_resp;
        first = 0; last = 0;
        for (int i = 0; i < 64; i++) begin
            send(PutFullData, 32'h0001_0200 + 32'(4*i), 32'(i) * 32'h0101_0101, 4'hF, 8'(i), 1'b0, 32'h0, 1'b0, acc);
            if (i == 0) first = acc;
            last = acc;
        end
        tl_i.a_valid = 1'b0;
        chk("stream_rate", 64'(last - first), 64'd63);
        @(negedge clk);
        while (cyc < last + 2) @(negedge clk);
        chk("stream_busy_hold", {63'h0, busy_o}, 64'h1);
        @(negedge clk);
        chk("stream_busy_fall", {63'h0, busy_o}, 64'h0);
        drain();
        chk("stream_acks", 64'(n_resp - r0), 64'd64);

        // Reset with 3 responses queued
        tl_i.d_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(Get, 32'h0001_0100 + 32'(4*i), 32'h0, 4'hF, 8'(20+i), 1'b0, 32'h0, 1'b0, acc);
        tl_i.a_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_d_valid", {63'h0, tl_o.d_valid}, 64'h0);
        chk("mid_rst_busy",    {63'h0, busy_o}, 64'h0);
        chk("mid_rst_err_cnt", 64'(err_cnt_o), 64'h0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        tl_i.d_ready = 1'b1;
        send(Get, 32'h0001_0010, 32'h0, 4'hF, 8'd9, 1'b0, 32'hDEAD_BEEF, 1'b1, acc);
        drain();
        chk("post_rst_err_cnt", 64'(err_cnt_o), 64'h0);
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
